bit_load_arbiter: RTL

BIT_LOAD_ARBITER -- requirements
Module: bit_load_arbiter

---
 rtl/bit_load_pkg.sv | 21 ++
 rtl/bit_load_arbiter_rr.sv | 18 +
 rtl/bit_load_arbiter.sv | 121 ++++++++++++
 3 files changed

// File: rtl/bit_load_pkg.sv
// Shared types and defaults for the bit-load arbiter.
// Optional parity state exists only when BIT_LOAD_PARITY_EN is defined.
package bit_load_pkg;

    localparam int WORD_W_DEF = 16;
    localparam int CNT_W_DEF  = 4;

`ifdef BIT_LOAD_PARITY_EN
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_t;
`else
    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;
`endif

endpackage

// File: rtl/bit_load_arbiter_rr.sv
// Two-way round-robin grant: the requester not served last wins a tie.
// Ports: req[1:0] requests, last = index served last, grant[1:0] one-hot.
module rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        unique case (1'b1)
            (req[0] && (!req[1] || last)): grant = 2'b01;
            (req[1] && (!req[0] || !last)): grant = 2'b10;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/bit_load_arbiter.sv
// Serialises words from two requesters LSB-first into the coding queue.
// Ports: clk, rst_n (async low); req0/req1, word0/word1 in, ack0/ack1 out;
//        queue_full in; bit_output, wrreq, busy out.
// Macro BIT_LOAD_PARITY_EN appends one even-parity bit after each word.
module bit_load_arbiter
    import bit_load_pkg::*;
#(
    parameter int WORD_W = WORD_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              req1,
    input  logic [WORD_W-1:0] word0,
    input  logic [WORD_W-1:0] word1,
    output logic              ack0,
    output logic              ack1,
    input  logic              queue_full,
    output logic              bit_output,
    output logic              wrreq,
    output logic              busy
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WORD_W - 1);

    state_t            state;
    state_t            state_d;
    logic [WORD_W-1:0] word_q;
    logic [WORD_W-1:0] word_d;
    logic [CNT_W-1:0]  index;
    logic [CNT_W-1:0]  index_d;
    logic              last;
    logic              last_d;
    logic              ack0_d;
    logic              ack1_d;
    logic              wrreq_d;
    logic              bit_d;
    logic [1:0]        grant;

    rr_arbiter2 u_rr (
        .req   ({req1, req0}),
        .last  (last),
        .grant (grant)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            word_q     <= '0;
            index      <= '0;
            last       <= 1'b1;
            ack0       <= 1'b0;
            ack1       <= 1'b0;
            wrreq      <= 1'b0;
            bit_output <= 1'b0;
        end else begin
            state      <= state_d;
            word_q     <= word_d;
            index      <= index_d;
            last       <= last_d;
            ack0       <= ack0_d;
            ack1       <= ack1_d;
            wrreq      <= wrreq_d;
            bit_output <= bit_d;
        end
    end

    // wrreq defaults low, so the IDLE cycle after the last write is
    // always a bubble even when a new grant happens at that edge.
    always_comb begin
        state_d = state;
        word_d  = word_q;
        index_d = index;
        last_d  = last;
        ack0_d  = 1'b0;
        ack1_d  = 1'b0;
        wrreq_d = 1'b0;
        bit_d   = bit_output;
        unique case (state)
            IDLE: begin
                if (|grant) begin
                    word_d  = grant[1] ? word1 : word0;
                    ack0_d  = grant[0];
                    ack1_d  = grant[1];
                    last_d  = grant[1];
                    index_d = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (!queue_full) begin
                    wrreq_d = 1'b1;
                    bit_d   = word_q[index];
                    if (index == LAST_IDX) begin
`ifdef BIT_LOAD_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = IDLE;
`endif
                    end else begin
                        index_d = index + CNT_W'(1);
                    end
                end
            end
`ifdef BIT_LOAD_PARITY_EN
            PARITY: begin
                if (!queue_full) begin
                    wrreq_d = 1'b1;
                    bit_d   = ^word_q;
                    state_d = IDLE;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

endmodule
